// File: rtl/ccff_chain_loader.sv
`timescale 1ns / 1ps
// ccff_chain_loader
//
// Programs one logic tile's configuration flip-flop chain (ccff_head -> ccff_tail).
// On start it flushes the chain with zeros, measures the chain length by walking a single
// 1 through it, then serialises bitstream words from a valid/ready source onto ccff_head.
// chain_shift_en qualifies each chain shift; an external clock gate derives the chain's
// shift clock from it.
//
// Ports:
//   prog_clk        sole clock, rising edge
//   pReset_n        asynchronous active-low reset
//   start           one-cycle load request, ignored while busy
//   abort           terminate the current operation (no effect when idle)
//   cfg_data        bitstream word, bit 0 shifted first
//   cfg_valid       cfg_data valid
//   cfg_ready       word accepted when cfg_valid & cfg_ready
//   ccff_head       serial bit into the chain
//   chain_shift_en  chain captures ccff_head at the end of this cycle
//   ccff_tail       serial bit out of the chain
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse after a successful load
//   err             sticky error flag, cleared by the next accepted start
//   err_code        0 none, 1 short chain, 2 long/open chain, 3 aborted
//
// Every output is a register; the next-state logic computes what the following cycle will
// present, so in any cycle chain_shift_en/ccff_head describe the shift happening in that cycle.

module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN   = 24,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PROBE_SLACK = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Word bookkeeping: the last word may carry fewer useful bits than DATA_W.
    localparam int unsigned NW        = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int unsigned LAST_BITS = CHAIN_LEN - (NW - 1) * DATA_W;
    localparam int unsigned PROBE_MAX = CHAIN_LEN + PROBE_SLACK;

    // Counter widths hold their largest value without wrapping.
    localparam int unsigned CNT_W   = $clog2(PROBE_MAX + 1);
    localparam int unsigned WORD_W  = $clog2(NW + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_W + 1);
    localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN + 1);

    localparam logic [CNT_W-1:0]   FLUSH_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]   PROBE_PASS  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]   PROBE_LIMIT = CNT_W'(PROBE_MAX);
    localparam logic [WORD_W-1:0]  LAST_WORD   = WORD_W'(NW - 1);
    localparam logic [BIT_W-1:0]   FULL_BITS   = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0]   TAIL_BITS   = BIT_W'(LAST_BITS);
    localparam logic [BIT_W-1:0]   ONE_BIT     = BIT_W'(1);
    localparam logic [SHIFT_W-1:0] LOAD_LAST   = SHIFT_W'(CHAIN_LEN - 1);

    // Sequencer states.
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFlush = 2'd1;
    localparam logic [1:0] StProbe = 2'd2;
    localparam logic [1:0] StLoad  = 2'd3;

    // Error codes.
    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrShort = 2'd1;
    localparam logic [1:0] ErrLong  = 2'd2;
    localparam logic [1:0] ErrAbort = 2'd3;

    // Sequencer state.
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;         // flush cycle / probe index
    logic [WORD_W-1:0]  words_q, words_d;     // words accepted in this load
    logic [BIT_W-1:0]   bits_q, bits_d;       // bits left in the shift buffer
    logic [DATA_W-1:0]  buf_q, buf_d;         // bit 0 is the bit on ccff_head now
    logic [SHIFT_W-1:0] shifted_q, shifted_d; // load shifts completed

    // Registered outputs.
    logic       shift_en_q, shift_en_d;
    logic       head_q, head_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    logic [DATA_W-1:0] buf_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        words_d    = words_q;
        bits_d     = bits_q;
        buf_d      = buf_q;
        shifted_d  = shifted_q;
        shift_en_d = 1'b0;
        head_d     = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        buf_next   = buf_q >> 1;

        if (state_q != StIdle && abort) begin
            // Abort wins over everything this cycle, including a final shift or probe hit.
            state_d    = StIdle;
            err_d      = 1'b1;
            err_code_d = ErrAbort;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StFlush;
                        cnt_d      = '0;
                        err_d      = 1'b0;
                        err_code_d = ErrNone;
                        shift_en_d = 1'b1;
                    end
                end

                StFlush: begin
                    shift_en_d = 1'b1;
                    if (cnt_q == FLUSH_LAST) begin
                        // Probe p=0 injects the single 1.
                        state_d = StProbe;
                        cnt_d   = '0;
                        head_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                StProbe: begin
                    if (cnt_q != '0 && ccff_tail) begin
                        if (cnt_q == PROBE_PASS) begin
                            state_d   = StLoad;
                            words_d   = '0;
                            bits_d    = '0;
                            shifted_d = '0;
                            ready_d   = 1'b1;
                        end else begin
                            // Early arrival means too few flops; late means too many.
                            state_d    = StIdle;
                            err_d      = 1'b1;
                            err_code_d = (cnt_q < PROBE_PASS) ? ErrShort : ErrLong;
                        end
                    end else if (cnt_q == PROBE_LIMIT) begin
                        state_d    = StIdle;
                        err_d      = 1'b1;
                        err_code_d = ErrLong;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        shift_en_d = 1'b1;
                    end
                end

                StLoad: begin
                    if (shift_en_q) begin
                        // The bit on ccff_head is captured at the end of this cycle.
                        buf_d     = buf_next;
                        bits_d    = bits_q - 1'b1;
                        shifted_d = shifted_q + 1'b1;
                        if (bits_q > ONE_BIT) begin
                            shift_en_d = 1'b1;
                            head_d     = buf_next[0];
                        end else if (shifted_q == LOAD_LAST) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            // Buffer drains this cycle; next cycle is the handshake bubble.
                            ready_d = 1'b1;
                        end
                    end else if (ready_q && cfg_valid) begin
                        buf_d      = cfg_data;
                        bits_d     = (words_q == LAST_WORD) ? TAIL_BITS : FULL_BITS;
                        words_d    = words_q + 1'b1;
                        shift_en_d = 1'b1;
                        head_d     = cfg_data[0];
                    end else begin
                        // Source stalled: keep offering, shift nothing.
                        ready_d = ready_q;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            words_q    <= '0;
            bits_q     <= '0;
            buf_q      <= '0;
            shifted_q  <= '0;
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            words_q    <= words_d;
            bits_q     <= bits_d;
            buf_q      <= buf_d;
            shifted_q  <= shifted_d;
            shift_en_q <= shift_en_d;
            head_q     <= head_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign cfg_ready      = ready_q;
    assign ccff_head      = head_q;
    assign chain_shift_en = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns / 1ps
// Scoreboard bench for ccff_chain_loader. Instance A uses the default 24-bit chain,
// instance B a 20-bit chain with a partial last word. Each instance drives a behavioural
// chain model. Stimulus pushes expected done/err events and output snapshots; a monitor
// on the falling edge pops and compares them.

module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       abort;
    logic [7:0] cfg_data;
    logic       cfg_valid;

    logic       start_a, tail_a, ready_a, head_a, sen_a, busy_a, done_a, err_a;
    logic [1:0] code_a;
    logic       start_b, tail_b, ready_b, head_b, sen_b, busy_b, done_b, err_b;
    logic [1:0] code_b;

    ccff_chain_loader #(.CHAIN_LEN(24), .DATA_W(8), .PROBE_SLACK(8)) u_dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_a), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
        .ccff_head(head_a), .chain_shift_en(sen_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .DATA_W(8), .PROBE_SLACK(8)) u_dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_b), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
        .ccff_head(head_b), .chain_shift_en(sen_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b)
    );

    // Cycle counter and chain models (index 0 is head-most).
    int          cyc = 0;
    logic [31:0] chain_a = '0;
    logic [31:0] chain_b = '0;
    int          shift_cnt_a = 0;
    int          shift_cnt_b = 0;
    logic [4:0]  tail_idx_a;
    bit          stuck_a;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sen_a) begin
            chain_a     <= {chain_a[30:0], head_a};
            shift_cnt_a <= shift_cnt_a + 1;
        end
        if (sen_b) begin
            chain_b     <= {chain_b[30:0], head_b};
            shift_cnt_b <= shift_cnt_b + 1;
        end
    end

    assign tail_a = stuck_a ? 1'b0 : chain_a[tail_idx_a];
    assign tail_b = chain_b[19];

    // Word source.
    logic [7:0] feed_q[$];
    bit         gaps;
    logic [7:0] gap_pat = 8'b1011_0110;
    bit         hs;

    initial begin
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = cfg_valid && (ready_a || ready_b);
            @(posedge clk);
            #1;
            if (hs && feed_q.size() > 0) void'(feed_q.pop_front());
            cfg_valid = (feed_q.size() > 0) && (!gaps || gap_pat[cyc[2:0]]);
            cfg_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
        end
    end

    // Scoreboard.
    typedef struct {
        int          inst;
        logic        is_done;
        logic [1:0]  code;
        int          cyc;
        int          shifts;
        logic        chk_chain;
        logic [31:0] chain;
        int          deadline;
    } ev_t;

    typedef struct {
        int          sel;
        logic [31:0] val;
    } snap_t;

    ev_t   ev_q[$];
    snap_t snap_q[$];

    int checks = 0;
    int failures = 0;
    int t0 = 0;
    int base_a = 0;
    int base_b = 0;
    int ready_base_a = 0;
    int ready_cnt_a = 0;
    int viol = 0;
    logic err_prev_a = 1'b0;
    logic err_prev_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    function automatic string snap_name(input int sel);
        case (sel)
            0:       return "outputs_a";
            1:       return "outputs_b";
            2:       return "ready_cycles_a";
            3:       return "ready_with_shift";
            default: return "words_left";
        endcase
    endfunction

    function automatic logic [31:0] snap_actual(input int sel);
        case (sel)
            0:       return {24'd0, busy_a, done_a, err_a, code_a, ready_a, sen_a, head_a};
            1:       return {24'd0, busy_b, done_b, err_b, code_b, ready_b, sen_b, head_b};
            2:       return 32'(ready_cnt_a - ready_base_a);
            3:       return 32'(viol);
            default: return 32'(feed_q.size());
        endcase
    endfunction

    task automatic on_event(input int inst, input logic is_done, input logic [1:0] code,
                            input logic bsy, input logic sen, input logic rdy, input logic er,
                            input int shifts, input logic [31:0] chain);
        ev_t e;
        if (ev_q.size() == 0) begin
            chk("unexpected_event", 32'(ev_q.size()), 32'd1);
        end else begin
            e = ev_q.pop_front();
            chk("event_inst", 32'(inst), 32'(e.inst));
            chk("event_is_done", 32'(is_done), 32'(e.is_done));
            chk("err_code", 32'(code), 32'(e.code));
            if (e.cyc >= 0) chk("event_cycle", 32'(cyc - t0), 32'(e.cyc));
            if (e.shifts >= 0) chk("shift_count", 32'(shifts), 32'(e.shifts));
            if (e.chk_chain) chk("chain_contents", chain, e.chain);
            if (is_done) begin
                chk("err_with_done", 32'(er), 32'd0);
            end else begin
                chk("busy_at_err", 32'(bsy), 32'd0);
                chk("shift_en_at_err", 32'(sen), 32'd0);
                chk("ready_at_err", 32'(rdy), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        snap_t s;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            chk(snap_name(s.sel), snap_actual(s.sel), s.val);
        end
        if (done_a || (err_a && !err_prev_a))
            on_event(0, done_a, code_a, busy_a, sen_a, ready_a, err_a,
                     shift_cnt_a - base_a, chain_a & 32'h00FF_FFFF);
        if (done_b || (err_b && !err_prev_b))
            on_event(1, done_b, code_b, busy_b, sen_b, ready_b, err_b,
                     shift_cnt_b - base_b, chain_b & 32'h000F_FFFF);
        if (ev_q.size() > 0 && cyc > ev_q[0].deadline) begin
            chk("event_timeout", 32'(cyc), 32'(ev_q[0].deadline));
            void'(ev_q.pop_front());
        end
        err_prev_a = err_a;
        err_prev_b = err_b;
        if (ready_a) ready_cnt_a++;
        if ((ready_a && sen_a) || (ready_b && sen_b)) viol++;
    end

    // Stimulus helpers.
    task automatic expect_ev(input int inst, input logic is_done, input logic [1:0] code,
                             input int c, input int shifts, input logic chk_chain,
                             input logic [31:0] chain);
        ev_t e;
        e.inst      = inst;
        e.is_done   = is_done;
        e.code      = code;
        e.cyc       = c;
        e.shifts    = shifts;
        e.chk_chain = chk_chain;
        e.chain     = chain;
        e.deadline  = cyc + 400;
        ev_q.push_back(e);
    endtask

    task automatic snap(input int sel, input logic [31:0] val);
        snap_t s;
        s.sel = sel;
        s.val = val;
        snap_q.push_back(s);
    endtask

    task automatic feed3(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        feed_q.push_back(w0);
        feed_q.push_back(w1);
        feed_q.push_back(w2);
    endtask

    // Leaves the bench at 1 ns into cycle 1 of the new operation.
    task automatic go(input int inst);
        @(posedge clk);
        #1;
        if (inst == 0) begin
            start_a      = 1'b1;
            base_a       = shift_cnt_a;
            ready_base_a = ready_cnt_a;
        end else begin
            start_b = 1'b1;
            base_b  = shift_cnt_b;
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain();
        while (ev_q.size() > 0) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    // Bit-reversed words: tail-most flop holds the first bit shifted in.
    localparam logic [31:0] NOMINAL_CHAIN = 32'h00A5_3C0F;  // A5, 3C, F0 over 24 flops
    localparam logic [31:0] PARTIAL_CHAIN = 32'h0005_AC3F;  // 5A, C3, FF[3:0] over 20 flops

    initial begin
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        abort      = 1'b0;
        tail_idx_a = 5'd23;
        stuck_a    = 1'b0;
        gaps       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap(0, 32'd0);
        snap(1, 32'd0);

        // Nominal load: done at cycle 77 after 24 + 25 + 24 shifts.
        feed3(8'hA5, 8'h3C, 8'hF0);
        expect_ev(0, 1'b1, 2'd0, 77, 73, 1'b1, NOMINAL_CHAIN);
        go(0);
        drain();
        snap(3, 32'd0);

        // Short chain (20 flops): tail hits at p=20 (cycle 45), err visible at 46.
        tail_idx_a = 5'd19;
        expect_ev(0, 1'b0, 2'd1, 46, 45, 1'b0, 32'd0);
        go(0);
        drain();
        snap(2, 32'd0);
        tail_idx_a = 5'd23;

        // Open chain: gives up at p=32 (cycle 57), err visible at 58.
        stuck_a = 1'b1;
        expect_ev(0, 1'b0, 2'd2, 58, 57, 1'b0, 32'd0);
        go(0);
        drain();
        stuck_a = 1'b0;

        // Abort during the 10th load shift (cycle 61).
        feed3(8'hA5, 8'h3C, 8'hF0);
        expect_ev(0, 1'b0, 2'd3, 62, 59, 1'b0, 32'd0);
        go(0);
        repeat (60) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        drain();
        feed_q.delete();

        // Restart after abort clears err and completes normally.
        feed3(8'hA5, 8'h3C, 8'hF0);
        expect_ev(0, 1'b1, 2'd0, 77, 73, 1'b1, NOMINAL_CHAIN);
        go(0);
        drain();

        // A second start while busy must not restart the sequence.
        feed3(8'hA5, 8'h3C, 8'hF0);
        expect_ev(0, 1'b1, 2'd0, 77, 73, 1'b1, NOMINAL_CHAIN);
        go(0);
        repeat (4) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        drain();

        // Partial last word on the 20-flop instance with source gaps.
        gaps = 1'b1;
        feed3(8'h5A, 8'hC3, 8'hFF);
        expect_ev(1, 1'b1, 2'd0, -1, 61, 1'b1, PARTIAL_CHAIN);
        go(1);
        drain();
        snap(3, 32'd0);
        snap(4, 32'd0);
        gaps = 1'b0;

        // Asynchronous reset in the middle of PROBE (cycle 30).
        go(0);
        repeat (29) @(posedge clk);
        #2;
        rst_n = 1'b0;
        snap(0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        snap(0, 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
